// File: rtl/spi_rdid_slave.sv
// SPI mode-0 RDID responder; returns DEVICE_ID on RDID_OPCODE.
// Define RDID_STATUS_READ_EN to add status_in and the 8'h05 status read.
module spi_rdid_slave #(
  parameter logic [23:0] DEVICE_ID   = 24'hEF4017,
  parameter logic [7:0]  RDID_OPCODE = 8'h9F,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_select,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       inst_valid,
  output logic [7:0] inst_byte,
  output logic       rdid_done
`ifdef RDID_STATUS_READ_EN
  ,
  input  logic [7:0] status_in
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_IGN  = 3'd3;
  localparam logic [2:0] S_ST   = 3'd4;

  localparam logic [7:0] STATUS_OPCODE = 8'h05;

  logic [SYNC_STAGES-1:0] r_sclk_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic                   r_sclk_d;

  logic [2:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_inst_sr;
  logic [4:0]  r_data_cnt;
  logic [23:0] r_tx_sr;

  logic        w_sclk;
  logic        w_cs;
  logic        w_mosi;
  logic        w_rise;
  logic        w_fall;
  logic [7:0]  w_rx_byte;
  logic        w_wrap;
  logic [23:0] w_reload;

  assign w_sclk    = r_sclk_s[SYNC_STAGES-1];
  assign w_cs      = r_cs_s[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_s[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_rx_byte = {r_inst_sr[6:0], w_mosi};

`ifdef RDID_STATUS_READ_EN
  assign w_wrap   = (r_state == S_ST) ? (r_data_cnt == 5'd7)
                                      : (r_data_cnt == 5'd23);
  assign w_reload = (r_state == S_ST) ? {status_in, 16'h0000}
                                      : DEVICE_ID;
`else
  assign w_wrap   = (r_data_cnt == 5'd23);
  assign w_reload = DEVICE_ID;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_s <= '0;
      r_cs_s   <= '0;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], chip_select};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
      r_sclk_d <= w_sclk;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_inst_sr  <= '0;
      r_data_cnt <= '0;
      r_tx_sr    <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      inst_valid <= 1'b0;
      inst_byte  <= 8'h00;
      rdid_done  <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      rdid_done  <= 1'b0;
      // Deselect has priority over any sclk edge seen in the same clk.
      if (r_state != S_IDLE && !w_cs) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= '0;
        r_inst_sr  <= '0;
        r_data_cnt <= '0;
        r_tx_sr    <= '0;
        miso       <= 1'b0;
        miso_oe    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_cs) begin
              r_state   <= S_RX;
              r_bit_cnt <= '0;
              r_inst_sr <= '0;
            end
          end
          S_RX: begin
            if (w_rise) begin
              r_inst_sr <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                inst_byte  <= w_rx_byte;
                inst_valid <= 1'b1;
                r_data_cnt <= '0;
                if (w_rx_byte == RDID_OPCODE) begin
                  r_state <= S_ID;
                  r_tx_sr <= DEVICE_ID;
`ifdef RDID_STATUS_READ_EN
                end else if (w_rx_byte == STATUS_OPCODE) begin
                  r_state <= S_ST;
                  r_tx_sr <= {status_in, 16'h0000};
`endif
                end else begin
                  r_state <= S_IGN;
                end
              end
            end
          end
          S_ID, S_ST: begin
            // Top bit goes out on each fall; reload makes the next fall restart.
            if (w_fall) begin
              miso    <= r_tx_sr[23];
              miso_oe <= 1'b1;
              r_tx_sr <= {r_tx_sr[22:0], 1'b0};
            end else if (w_rise) begin
              if (w_wrap) begin
                r_data_cnt <= '0;
                r_tx_sr    <= w_reload;
                rdid_done  <= (r_state == S_ID);
              end else begin
                r_data_cnt <= r_data_cnt + 5'd1;
              end
            end
          end
          S_IGN: begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic w_unused;
  assign w_unused = ^STATUS_OPCODE;

endmodule

// File: tb/tb_spi_rdid_slave.sv
// Directed bench for spi_rdid_slave: RDID, wrap, unknown op,
// partial deselect, async reset and optional status read.
module tb_spi_rdid_slave;

  localparam int HALF = 6;

  logic       clk;
  logic       reset;
  logic       chip_select;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       inst_valid;
  logic [7:0] inst_byte;
  logic       rdid_done;
`ifdef RDID_STATUS_READ_EN
  logic [7:0] status_in;
`endif

  spi_rdid_slave dut (
    .clk         (clk),
    .reset       (reset),
    .chip_select (chip_select),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .inst_valid  (inst_valid),
    .inst_byte   (inst_byte),
    .rdid_done   (rdid_done)
`ifdef RDID_STATUS_READ_EN
    ,
    .status_in   (status_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_iv   = 0;
  int n_done = 0;
  int n_wide = 0;
  logic r_piv = 1'b0;
  logic r_pdn = 1'b0;

  always @(negedge clk) begin
    if (inst_valid) n_iv <= n_iv + 1;
    if (rdid_done) n_done <= n_done + 1;
    if ((inst_valid && r_piv) || (rdid_done && r_pdn))
      n_wide <= n_wide + 1;
    r_piv <= inst_valid;
    r_pdn <= rdid_done;
  end

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b, output logic s, output logic o);
    mosi = b;
    tick(HALF);
    s = miso;
    o = miso_oe;
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
  endtask

  // ni instruction bits of op, then nd data bits; rx collects miso.
  task automatic xfer(input logic [7:0] op, input int ni, input int nd,
                      input bit hold, output logic [47:0] rx,
                      output int noe);
    logic s;
    logic o;
    rx  = '0;
    noe = 0;
    chip_select = 1'b1;
    tick(HALF);
    for (int i = 0; i < ni; i++) spi_bit(op[7-i], s, o);
    for (int i = 0; i < nd; i++) begin
      spi_bit(1'b0, s, o);
      rx = {rx[46:0], s};
      if (o) noe++;
    end
    mosi = 1'b0;
    if (!hold) begin
      tick(HALF);
      chip_select = 1'b0;
      tick(HALF);
    end
  endtask

  logic [47:0] rx;
  int noe;
  int iv0;
  int dn0;

  initial begin
    reset = 1'b0;
    chip_select = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
`ifdef RDID_STATUS_READ_EN
    status_in = 8'hA5;
`endif
    tick(3);
    chk("reset_outs", {36'h0, miso, miso_oe, inst_valid, inst_byte,
        rdid_done}, 48'h0);
    reset = 1'b1;
    tick(4);

    iv0 = n_iv; dn0 = n_done;
    xfer(8'h9F, 8, 24, 1'b0, rx, noe);
    chk("rdid_byte", {40'h0, inst_byte}, 48'h9F);
    chk("rdid_iv", 48'(n_iv - iv0), 48'd1);
    chk("rdid_id", rx, 48'h000000EF4017);
    chk("rdid_done", 48'(n_done - dn0), 48'd1);
    chk("rdid_oe", 48'(noe), 48'd24);
    chk("idle_oe", {47'h0, miso_oe}, 48'h0);

    iv0 = n_iv; dn0 = n_done;
    xfer(8'h9F, 8, 48, 1'b0, rx, noe);
    chk("wrap_id", rx, 48'hEF4017EF4017);
    chk("wrap_done", 48'(n_done - dn0), 48'd2);
    chk("wrap_iv", 48'(n_iv - iv0), 48'd1);

    iv0 = n_iv; dn0 = n_done;
    xfer(8'hAB, 8, 16, 1'b0, rx, noe);
    chk("ign_byte", {40'h0, inst_byte}, 48'hAB);
    chk("ign_miso", rx, 48'h0);
    chk("ign_oe", 48'(noe), 48'd0);
    chk("ign_done", 48'(n_done - dn0), 48'd0);
    chk("ign_iv", 48'(n_iv - iv0), 48'd1);

    iv0 = n_iv;
    xfer(8'h9F, 5, 0, 1'b0, rx, noe);
    chk("part_iv", 48'(n_iv - iv0), 48'd0);
    chk("part_byte", {40'h0, inst_byte}, 48'hAB);
    dn0 = n_done;
    xfer(8'h9F, 8, 24, 1'b0, rx, noe);
    chk("part_next_id", rx, 48'h000000EF4017);
    chk("part_next_done", 48'(n_done - dn0), 48'd1);

    xfer(8'h9F, 8, 10, 1'b1, rx, noe);
    chk("mid_oe", {47'h0, miso_oe}, 48'h1);
    chk("mid_bits", rx, 48'h3BD);
    reset = 1'b0;
    #1;
    chk("rst_async", {36'h0, miso, miso_oe, inst_valid, inst_byte,
        rdid_done}, 48'h0);
    chip_select = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(4);
    dn0 = n_done;
    xfer(8'h9F, 8, 24, 1'b0, rx, noe);
    chk("post_rst_id", rx, 48'h000000EF4017);
    chk("post_rst_done", 48'(n_done - dn0), 48'd1);

`ifdef RDID_STATUS_READ_EN
    dn0 = n_done;
    xfer(8'h05, 8, 16, 1'b0, rx, noe);
    chk("st_byte", {40'h0, inst_byte}, 48'h05);
    chk("st_bits", rx, 48'h0000A5A5);
    chk("st_done", 48'(n_done - dn0), 48'd0);
    chk("st_oe", 48'(noe), 48'd16);
`else
    dn0 = n_done;
    xfer(8'h05, 8, 16, 1'b0, rx, noe);
    chk("op05_miso", rx, 48'h0);
    chk("op05_oe", 48'(noe), 48'd0);
    chk("op05_done", 48'(n_done - dn0), 48'd0);
`endif

    tick(2);
    chk("pulse_width", 48'(n_wide), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
